// File: rtl/wallace_mult_pipe.sv
// wallace_mult_pipe
//   Pipelined unsigned Wallace-tree multiplier with a valid/ready stream
//   interface and a sideband tag that travels with each operation.
//   Operands are expanded into WIDTH partial-product rows at the input and
//   captured (stage 0). The rows are then reduced by 3:2 carry-save layers
//   spread over PIPE tree stages. The last stage also performs the final
//   carry-propagate add. The whole pipeline advances together whenever the
//   output slot is free or being consumed.
//
//   Optional feature: define WALLACE_APPROX_EN to build the approximate mode.
//   In that mode, in_approx per op zeroes partial products of weight
//   < APPROX_COLS. Without the macro, in_approx is ignored, out_approx is 0,
//   and every product is exact.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   synchronous active-low reset
//   in_valid    in   operand pair valid
//   in_ready    out  operand pair can be accepted this cycle
//   in_a/in_b   in   WIDTH-bit unsigned operands
//   in_approx   in   request approximate product
//   in_tag      in   TAG_W sideband tag
//   out_valid   out  result valid
//   out_ready   in   consumer accepts result
//   out_product out  2*WIDTH-bit product
//   out_approx  out  product was computed approximately
//   out_tag     out  tag of this result
module wallace_mult_pipe #(
  parameter int WIDTH       = 8,
  parameter int PIPE        = 2,
  parameter int TAG_W       = 4,
  parameter int APPROX_COLS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_approx,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic               out_approx,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int P = 2 * WIDTH;

  // One full-width row per multiplier bit; rows beyond the live count are 0.
  typedef logic [WIDTH-1:0][P-1:0] rows_t;

  // Live row count after l carry-save layers.
  function automatic int rows_after(input int l);
    int r;
    r = WIDTH;
    for (int k = 0; k < l; k++) r = 2 * (r / 3) + (r % 3);
    return r;
  endfunction

  function automatic int num_layers();
    int r;
    int n;
    r = WIDTH;
    n = 0;
    while (r > 2) begin
      r = 2 * (r / 3) + (r % 3);
      n++;
    end
    return n;
  endfunction

  localparam int NL = num_layers();

  // One 3:2 layer over the n live rows: each full group of three rows becomes
  // a sum row and a carry row (shifted up one column); leftover rows pass
  // through. Carries out of the top column are always 0 because the product
  // fits in 2*WIDTH bits.
  function automatic rows_t csa_layer(input rows_t r, input int n);
    rows_t o;
    int    g3;
    o  = '0;
    g3 = n / 3;
    for (int g = 0; g < WIDTH / 3; g++) begin
      if (g < g3) begin
        o[2*g]   = r[3*g] ^ r[3*g+1] ^ r[3*g+2];
        o[2*g+1] = ((r[3*g] & r[3*g+1]) | (r[3*g] & r[3*g+2]) |
                    (r[3*g+1] & r[3*g+2])) << 1;
      end
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (i >= 3 * g3 && i < n) o[i-g3] = r[i];
    end
    return o;
  endfunction

  // Tree stage s (1..PIPE) runs layers [(s-1)*NL/PIPE, s*NL/PIPE), which
  // spreads the layers as evenly as integer division allows.
  function automatic rows_t reduce_stage(input rows_t r, input int s);
    rows_t c;
    c = r;
    for (int l = 0; l < NL; l++) begin
      if (l >= ((s - 1) * NL) / PIPE && l < (s * NL) / PIPE)
        c = csa_layer(c, rows_after(l));
    end
    return c;
  endfunction

  function automatic logic [P-1:0] final_sum(input rows_t r);
    rows_t c;
    c = reduce_stage(r, PIPE);
    return c[0] + c[1];
  endfunction

  logic                adv;
  logic [PIPE:0]       vld_q;
  logic [TAG_W-1:0]    tag_q [PIPE+1];
  rows_t               tree_q [PIPE];
  rows_t               tree_d [PIPE];
  logic [P-1:0]        prod_q;
  logic [P-1:0]        prod_d;
  logic [WIDTH-1:0]    keep;

  assign adv         = out_ready | ~vld_q[PIPE];
  assign in_ready    = adv;
  assign out_valid   = vld_q[PIPE];
  assign out_product = prod_q;
  assign out_tag     = tag_q[PIPE];

  // Stage 0 input: partial-product rows. Later stages: carry-save reduction.
  always_comb begin
    keep = '0;
    for (int s = 0; s < PIPE; s++) tree_d[s] = '0;
    for (int j = 0; j < WIDTH; j++) begin
      keep = in_a;
`ifdef WALLACE_APPROX_EN
      if (in_approx) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (i + j < APPROX_COLS) keep[i] = 1'b0;
        end
      end
`endif
      if (in_b[j]) tree_d[0][j] = P'(keep) << j;
    end
    for (int s = 1; s < PIPE; s++) tree_d[s] = reduce_stage(tree_q[s-1], s);
    prod_d = final_sum(tree_q[PIPE-1]);
  end

  // Stage 0 capture and tree stages 1..PIPE-1 (data only, not reset).
  always_ff @(posedge clk) begin
    if (adv) begin
      if (in_valid) tree_q[0] <= tree_d[0];
      for (int s = 1; s < PIPE; s++) begin
        if (vld_q[s-1]) tree_q[s] <= tree_d[s];
      end
    end
  end

  // Valid/tag shift and final stage (carry-propagate add into prod_q).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q  <= '0;
      prod_q <= '0;
      for (int s = 0; s <= PIPE; s++) tag_q[s] <= '0;
    end else if (adv) begin
      vld_q <= {vld_q[PIPE-1:0], in_valid};
      if (in_valid) tag_q[0] <= in_tag;
      for (int s = 1; s <= PIPE; s++) begin
        if (vld_q[s-1]) tag_q[s] <= tag_q[s-1];
      end
      if (vld_q[PIPE-1]) prod_q <= prod_d;
    end
  end

`ifdef WALLACE_APPROX_EN
  logic [PIPE:0] apx_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      apx_q <= '0;
    end else if (adv) begin
      apx_q <= {apx_q[PIPE-1:0], in_approx};
    end
  end

  assign out_approx = apx_q[PIPE];
`else
  logic [1:0] unused_cfg;
  assign unused_cfg = {in_approx, 1'(APPROX_COLS)};
  assign out_approx = 1'b0;
`endif

endmodule

// File: tb/tb_wallace_mult_pipe.sv
module tb_wallace_mult_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

`ifdef WALLACE_APPROX_EN
  localparam logic APX_ON = 1'b1;
`else
  localparam logic APX_ON = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] p;
    logic [3:0]  t;
    logic        a;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];

  // 8x8, PIPE=2 instance
  logic        rst8_n, iv8, ir8, apx8, ov8, ordy8, oapx8;
  logic [7:0]  a8, b8;
  logic [3:0]  tag8, tag8o;
  logic [15:0] prod8;

  // 4x4, PIPE=1 instance
  logic        rst4_n, iv4, ir4, apx4, ov4, ordy4, oapx4;
  logic [3:0]  a4, b4;
  logic [3:0]  tag4, tag4o;
  logic [7:0]  prod4;

  wallace_mult_pipe #(.WIDTH(8), .PIPE(2), .TAG_W(4), .APPROX_COLS(4)) u_dut8 (
    .clk(clk), .rst_n(rst8_n), .in_valid(iv8), .in_ready(ir8), .in_a(a8), .in_b(b8),
    .in_approx(apx8), .in_tag(tag8), .out_valid(ov8), .out_ready(ordy8),
    .out_product(prod8), .out_approx(oapx8), .out_tag(tag8o));

  wallace_mult_pipe #(.WIDTH(4), .PIPE(1), .TAG_W(4), .APPROX_COLS(4)) u_dut4 (
    .clk(clk), .rst_n(rst4_n), .in_valid(iv4), .in_ready(ir4), .in_a(a4), .in_b(b4),
    .in_approx(apx4), .in_tag(tag4), .out_valid(ov4), .out_ready(ordy4),
    .out_product(prod4), .out_approx(oapx4), .out_tag(tag4o));

  // Golden product: exact a*b, minus dropped terms of weight < 4 in approx mode.
  function automatic logic [15:0] model(input int w, input logic [7:0] a,
                                        input logic [7:0] b, input logic apx);
    int unsigned r;
    r = a * b;
    if (apx) begin
      for (int i = 0; i < w; i++)
        for (int j = 0; j < w; j++)
          if (i + j < 4 && a[i] && b[j]) r = r - (32'd1 << (i + j));
    end
    return r[15:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  logic        hold8 = 1'b0, hold4 = 1'b0;
  logic [15:0] hp8;
  logic [7:0]  hp4;
  logic [3:0]  ht8, ht4;
  logic        acc8, acc4;
  int          npop8 = 0, first_pop8 = 0, last_pop8 = 0;

  // One clock: sample both DUTs at the falling edge, then return just after
  // the next rising edge so the caller can drive new inputs.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    acc8 = 1'b0;
    acc4 = 1'b0;
    if (!rst8_n) begin
      q8.delete();
      hold8 = 1'b0;
    end else begin
      if (hold8) begin
        chk("dut8_hold_product", prod8, hp8);
        chk("dut8_hold_tag", tag8o, ht8);
        chk("dut8_hold_valid", ov8, 1);
      end
      if (ov8 && ordy8) begin
        checks++;
        assert (q8.size() > 0) else begin
          failures++;
          $error("FAIL dut8_extra_result observed=%0h expected=none", prod8);
        end
        if (q8.size() > 0) begin
          e = q8.pop_front();
          chk("dut8_product", prod8, e.p);
          chk("dut8_tag", tag8o, e.t);
          chk("dut8_approx", oapx8, e.a);
          if (npop8 == 0) first_pop8 = cyc;
          last_pop8 = cyc;
          npop8++;
        end
      end
      if (iv8 && ir8) begin
        q8.push_back('{p: model(8, a8, b8, apx8 & APX_ON), t: tag8, a: apx8 & APX_ON});
        acc8 = 1'b1;
      end
      hold8 = ov8 && !ordy8;
      hp8   = prod8;
      ht8   = tag8o;
    end
    if (!rst4_n) begin
      q4.delete();
      hold4 = 1'b0;
    end else begin
      if (hold4) begin
        chk("dut4_hold_product", prod4, hp4);
        chk("dut4_hold_tag", tag4o, ht4);
      end
      if (ov4 && ordy4) begin
        checks++;
        assert (q4.size() > 0) else begin
          failures++;
          $error("FAIL dut4_extra_result observed=%0h expected=none", prod4);
        end
        if (q4.size() > 0) begin
          e = q4.pop_front();
          chk("dut4_product", prod4, e.p);
          chk("dut4_tag", tag4o, e.t);
          chk("dut4_approx", oapx4, e.a);
        end
      end
      if (iv4 && ir4) begin
        q4.push_back('{p: model(4, {4'b0, a4}, {4'b0, b4}, 1'b0), t: tag4, a: 1'b0});
        acc4 = 1'b1;
      end
      hold4 = ov4 && !ordy4;
      hp4   = prod4;
      ht4   = tag4o;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out8();
    int n;
    n = 0;
    while (!ov8 && n < 10) begin
      tick();
      n++;
    end
    if (!ov8) chk("dut8_wait_timeout", ov8, 1);
  endtask

  task automatic drain8();
    int n;
    n = 0;
    iv8   = 1'b0;
    ordy8 = 1'b1;
    while ((q8.size() != 0 || ov8) && n < 20) begin
      tick();
      n++;
    end
    chk("dut8_drained", q8.size(), 0);
  endtask

  initial begin
    int         issued;
    int         p;
    int         guard;
    int         sz;
    logic       did_rst;
    logic [7:0] na, nb;
    logic [3:0] nt;

    // Reset held two cycles with traffic on the input.
    rst8_n = 1'b0; iv8 = 1'b1; a8 = 8'd3; b8 = 8'd3; apx8 = 1'b0; tag8 = 4'd7; ordy8 = 1'b0;
    rst4_n = 1'b0; iv4 = 1'b1; a4 = 4'd3; b4 = 4'd3; apx4 = 1'b0; tag4 = 4'd7; ordy4 = 1'b1;
    tick();
    tick();
    chk("reset_out_valid8", ov8, 0);
    chk("reset_product8", prod8, 0);
    chk("reset_tag8", tag8o, 0);
    chk("reset_approx8", oapx8, 0);
    chk("reset_out_valid4", ov4, 0);
    chk("reset_product4", prod4, 0);
    rst8_n = 1'b1;
    rst4_n = 1'b1;
    iv8 = 1'b0;
    iv4 = 1'b0;
    chk("ready_after_reset", ir8, 1);

    // 255*255 latency: accepted at edge k, visible after edge k+2.
    ordy8 = 1'b1; iv8 = 1'b1; a8 = 8'd255; b8 = 8'd255; tag8 = 4'd5;
    tick();
    chk("lat_accept", acc8, 1);
    iv8 = 1'b0;
    chk("lat_edge_k", ov8, 0);
    tick();
    chk("lat_edge_k1", ov8, 0);
    tick();
    chk("lat_edge_k2_valid", ov8, 1);
    chk("lat_edge_k2_product", prod8, 16'hFE01);
    chk("lat_edge_k2_tag", tag8o, 5);
    drain8();

    // Ten back-to-back random ops, one result per cycle.
    npop8 = 0;
    for (int i = 0; i < 10; i++) begin
      iv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); tag8 = 4'(i);
      tick();
      chk("stream_accept", acc8, 1);
    end
    iv8 = 1'b0;
    for (int k = 0; k < 20; k++) if (npop8 < 10) tick();
    chk("stream_count", npop8, 10);
    chk("stream_back_to_back", last_pop8 - first_pop8, 9);
    drain8();

    // Streaming with a five-cycle consumer stall in the middle.
    npop8  = 0;
    issued = 0;
    na = 8'($urandom); nb = 8'($urandom); nt = 4'($urandom);
    for (int c = 0; c < 40; c++) begin
      iv8 = (issued < 20); a8 = na; b8 = nb; tag8 = nt; apx8 = 1'b0;
      ordy8 = !(c >= 8 && c < 13);
      if (c >= 8 && c < 13) begin
        #1;
        chk("stall_in_ready", ir8, 0);
      end
      tick();
      if (acc8) begin
        issued++;
        na = 8'($urandom); nb = 8'($urandom); nt = 4'($urandom);
      end
    end
    drain8();
    chk("stall_issued", issued, 20);
    chk("stall_no_loss", npop8, issued);

    // Approximate mode on 0x0F * 0x0F.
    iv8 = 1'b1; a8 = 8'h0F; b8 = 8'h0F; apx8 = 1'b1; tag8 = 4'd1;
    tick();
    iv8 = 1'b0;
    wait_out8();
    chk("approx_on_product", prod8, APX_ON ? 16'h00B0 : 16'h00E1);
    chk("approx_on_flag", oapx8, APX_ON);
    drain8();
    iv8 = 1'b1; a8 = 8'h0F; b8 = 8'h0F; apx8 = 1'b0; tag8 = 4'd2;
    tick();
    iv8 = 1'b0;
    wait_out8();
    chk("approx_off_product", prod8, 16'h00E1);
    chk("approx_off_flag", oapx8, 0);
    drain8();

    // 4x4, PIPE=1: every operand pair, random backpressure, reset mid-run.
    p       = 0;
    guard   = 0;
    did_rst = 1'b0;
    while (p < 256 && guard < 5000) begin
      guard++;
      if (p == 128 && !did_rst) begin
        did_rst = 1'b1;
        sz      = q4.size();
        rst4_n  = 1'b0;
        iv4     = 1'b0;
        tick();
        rst4_n  = 1'b1;
        chk("dut4_no_stale_after_reset", ov4, 0);
        p = p - sz;
      end else begin
        iv4 = 1'b1; a4 = 4'(p >> 4); b4 = 4'(p); tag4 = 4'($urandom);
        ordy4 = ($urandom_range(0, 3) != 0);
        tick();
        if (acc4) p++;
      end
    end
    iv4   = 1'b0;
    ordy4 = 1'b1;
    for (int k = 0; k < 20; k++) if (q4.size() != 0 || ov4) tick();
    chk("dut4_all_issued", p, 256);
    chk("dut4_drained", q4.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
